deadlock_idx0_monitor: RTL and testbench



---
 rtl/deadlock_mon_pkg.sv | 15 +
 rtl/deadlock_persist_cnt.sv | 57 +++++
 rtl/deadlock_idx0_monitor.sv | 66 ++++++
 tb/tb_deadlock_idx0_monitor.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/deadlock_mon_pkg.sv
// Shared defaults and the stall rule for the kernel deadlock monitors.
// Used by the idx0 monitor top and by its persistence counter.
package deadlock_mon_pkg;

  localparam int DEF_AXIS_W    = 1;
  localparam int DEF_IDLE_W    = 2;
  localparam int DEF_BLK_W     = 1;
  localparam int DEF_THRESHOLD = 1000;

  // A kernel that is fully idle is never stalled, whatever its block flags say.
  function automatic logic stall_calc(input logic axis_any, input logic idle_all, input logic blk_any);
    return (axis_any | blk_any) & ~idle_all;
  endfunction

endpackage

// File: rtl/deadlock_persist_cnt.sv
// Saturating count of consecutive stalled cycles.
// 'hit' pulses on the cycle whose rising edge completes THRESHOLD stalled edges.
module deadlock_persist_cnt
  import deadlock_mon_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic stall_now,
  output logic hit
);

  localparam int             CW     = $clog2(THRESHOLD + 1);
  localparam logic [CW-1:0]  THR_C  = CW'(THRESHOLD);
  localparam logic [CW-1:0]  THR_M1 = CW'(THRESHOLD - 1);
  localparam logic [CW-1:0]  ONE_C  = CW'(1);
  localparam logic [CW-1:0]  ZERO_C = CW'(0);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          hit_s;

  // Next count: clear on any non-stalled cycle, otherwise climb and hold at THRESHOLD.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (!stall_now) begin
      cnt_nxt_s = ZERO_C;
    end else if (cnt_r < THR_C) begin
      cnt_nxt_s = cnt_r + ONE_C;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= ZERO_C;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Fires once per run: after saturation cnt_r sits at THRESHOLD, not THRESHOLD-1.
  always_comb begin
    hit_s = 1'b0;
    if (stall_now && (cnt_r == THR_M1)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  assign hit = hit_s;

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for kernel idx0: flags a stall that persists THRESHOLD cycles.
// 'block' is a sticky register cleared only by reset.
module deadlock_idx0_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int AXIS_W    = DEF_AXIS_W,
  parameter int IDLE_W    = DEF_IDLE_W,
  parameter int BLK_W     = DEF_BLK_W,
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AXIS_W-1:0] axis_block_sigs,
  input  logic [IDLE_W-1:0] inst_idle_sigs,
  input  logic [BLK_W-1:0]  inst_block_sigs,
  output logic              block
);

  logic [AXIS_W-1:0] axis_clean_s;
  logic [IDLE_W-1:0] idle_clean_s;
  logic [BLK_W-1:0]  blk_clean_s;
  logic              axis_any_s;
  logic              idle_all_s;
  logic              blk_any_s;
  logic              stall_now_s;
  logic              hit_s;
  logic              block_r;

  // Unknown flags from the simulated hierarchy count as inactive, keeping stall_now known.
  always_comb begin
    axis_clean_s = {AXIS_W{1'b0}};
    idle_clean_s = {IDLE_W{1'b0}};
    blk_clean_s  = {BLK_W{1'b0}};
    for (int i = 0; i < AXIS_W; i++) axis_clean_s[i] = (axis_block_sigs[i] === 1'b1);
    for (int i = 0; i < IDLE_W; i++) idle_clean_s[i] = (inst_idle_sigs[i] === 1'b1);
    for (int i = 0; i < BLK_W; i++)  blk_clean_s[i]  = (inst_block_sigs[i] === 1'b1);
  end

  assign axis_any_s  = |axis_clean_s;
  assign idle_all_s  = &idle_clean_s;
  assign blk_any_s   = |blk_clean_s;
  assign stall_now_s = stall_calc(axis_any_s, idle_all_s, blk_any_s);

  deadlock_persist_cnt #(
    .THRESHOLD (THRESHOLD)
  ) u_persist (
    .clock     (clock),
    .reset     (reset),
    .stall_now (stall_now_s),
    .hit       (hit_s)
  );

  // Sticky deadlock flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      block_r <= 1'b0;
    end else if (hit_s) begin
      block_r <= 1'b1;
    end else begin
      block_r <= block_r;
    end
  end

  assign block = block_r;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Directed bench for deadlock_idx0_monitor (THRESHOLD=8) against a run-length model.
module tb_deadlock_idx0_monitor;

  localparam int THR = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [0:0] axis_block_sigs = 1'b0;
  logic [1:0] inst_idle_sigs  = 2'b00;
  logic [0:0] inst_block_sigs = 1'b0;
  logic       block;

  int checks = 0;
  int errors = 0;

  // model state: length of the current stall run and the sticky verdict
  int   run_len   = 0;
  logic mdl_block = 1'b0;
  logic prev_blk  = 1'b0;
  logic reset_seen = 1'b1;
  logic started   = 1'b0;

  deadlock_idx0_monitor #(
    .THRESHOLD (THR)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block)
  );

  always #5 clock = ~clock;

  function automatic bit model_stall();
    int waiting;
    int idle_cnt;
    waiting  = $countones(axis_block_sigs) + $countones(inst_block_sigs);
    idle_cnt = $countones(inst_idle_sigs);
    return (waiting > 0) && (idle_cnt != 2);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      run_len   = 0;
      mdl_block = 1'b0;
    end else begin
      if (model_stall()) run_len = run_len + 1;
      else               run_len = 0;
      if (run_len >= THR) mdl_block = 1'b1;
    end
  end

  always @(posedge reset) reset_seen = 1'b1;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, plus the never-falls-without-reset rule
  always @(negedge clock) begin
    if (started) begin
      chk("model", block, mdl_block);
      if (prev_blk && !reset_seen) chk("sticky", block, 1'b1);
    end
    prev_blk   = block;
    reset_seen = reset;
  end

  task automatic run(input logic a, input logic [1:0] i, input logic b, input int n);
    axis_block_sigs = a;
    inst_idle_sigs  = i;
    inst_block_sigs = b;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(1'b0, 2'b00, 1'b0, 2);
    reset = 1'b0;
  endtask

  initial begin
    started = 1'b1;
    // 1) reset held with arbitrary inputs
    run(1'($urandom), 2'($urandom), 1'($urandom), 3);
    chk("reset_hold", block, 1'b0);
    reset = 1'b0;

    // 2) AXIS stall alone: rises on the 8th edge, then sticky
    run(1'b1, 2'b10, 1'b0, 7);
    chk("axis_7", block, 1'b0);
    run(1'b1, 2'b10, 1'b0, 1);
    chk("axis_8", block, 1'b1);
    run(1'b0, 2'b00, 1'b0, 100);
    chk("sticky_100", block, 1'b1);

    // asynchronous clear between edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", block, 1'b0);
    run(1'b0, 2'b00, 1'b0, 1);
    reset = 1'b0;

    // 3) one clean cycle restarts the count
    run(1'b1, 2'b10, 1'b0, 7);
    chk("gap_pre", block, 1'b0);
    run(1'b0, 2'b10, 1'b0, 1);
    chk("gap_idle", block, 1'b0);
    run(1'b1, 2'b10, 1'b0, 7);
    chk("gap_post7", block, 1'b0);
    run(1'b1, 2'b10, 1'b0, 1);
    chk("gap_post8", block, 1'b1);
    do_reset();

    // 4) fully idle kernel is never stalled
    run(1'b1, 2'b11, 1'b1, 50);
    chk("all_idle", block, 1'b0);

    // 5) instance blocking alone
    run(1'b0, 2'b00, 1'b1, 7);
    chk("inst_7", block, 1'b0);
    run(1'b0, 2'b00, 1'b1, 1);
    chk("inst_8", block, 1'b1);
    do_reset();

    // 6) long stall: counter saturates, flag stays up
    run(1'b1, 2'b01, 1'b0, 1000);
    chk("long_block", block, 1'b1);
    checks++;
    if (dut.u_persist.cnt_r !== 4'd8) begin
      errors++;
      $display("FAIL saturate: got %0d expected 8", dut.u_persist.cnt_r);
    end
    run(1'b0, 2'b00, 1'b0, 5);
    chk("end_sticky", block, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
